// File: rtl/pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_arbiter
// Description : Round-robin arbiter that shares the input of one pipe among
//               NUM_REQ valid/ready requesters. The winning payload lands in
//               a one-entry output register that feeds the pipe and is
//               back-pressured by the pipe's full flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : NUM_REQ   - number of requesters (>= 2)
//               DATA_SIZE - payload width per requester
//               ID_W      - grant index width, derived from NUM_REQ
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               req_valid_i  - per-requester request valid
//               req_data_i   - packed payloads, requester i at
//                              [i*DATA_SIZE +: DATA_SIZE]
//               req_lock_i   - per-requester lock request
//               req_ready_o  - per-requester accept (one-hot or zero)
//               pipe_full_i  - full flag from the downstream pipe
//               pipe_data_o  - payload to the pipe
//               pipe_valid_o - valid to the pipe
//               pipe_id_o    - requester index of the registered payload
//               locked_o     - grant is locked to one requester
// Build macro : PIPE_ARB_LOCK_EN - when defined, req_lock_i is honoured and a
//               handshake with lock set keeps the grant on that requester
//               until it completes a beat with lock clear. When undefined,
//               req_lock_i is ignored and locked_o is tied low.
// ============================================================================
module pipe_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 32,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]            req_lock_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          pipe_full_i,
  output logic [DATA_SIZE-1:0]          pipe_data_o,
  output logic                          pipe_valid_o,
  output logic [ID_W-1:0]               pipe_id_o,
  output logic                          locked_o
);

  localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   c_num_req = (ID_W + 1)'(NUM_REQ);

  // Output register and round-robin pointer
  logic                 r_out_valid;
  logic [DATA_SIZE-1:0] r_out_data;
  logic [ID_W-1:0]      r_out_id;
  logic [ID_W-1:0]      r_ptr;

  logic                 w_scan_found;
  logic [ID_W-1:0]      w_scan_idx;
  logic                 w_has_win;
  logic [ID_W-1:0]      w_win;
  logic                 w_locked;
  logic                 w_can_load;
  logic                 w_hs;
  logic [DATA_SIZE-1:0] w_win_data;

  // The register may take a new beat when empty or when its beat leaves now.
  assign w_can_load = !r_out_valid || !pipe_full_i;

  // Rotating priority scan starting at r_ptr. The sum is one bit wider than
  // the index so the wrap can be done with a single subtraction, which keeps
  // it correct for non-power-of-two NUM_REQ.
  always_comb begin
    logic [ID_W:0] v_sum;
    w_scan_found = 1'b0;
    w_scan_idx   = '0;
    v_sum        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_sum = {1'b0, r_ptr} + (ID_W + 1)'(i);
      if (v_sum >= c_num_req) begin
        v_sum = v_sum - c_num_req;
      end
      if (!w_scan_found && req_valid_i[v_sum[ID_W-1:0]]) begin
        w_scan_found = 1'b1;
        w_scan_idx   = v_sum[ID_W-1:0];
      end
    end
  end

`ifdef PIPE_ARB_LOCK_EN
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_lock_id;

  assign w_locked  = (r_state == ST_LOCKED);
  // While locked the owner is the only candidate, even when it is idle.
  assign w_win     = w_locked ? r_lock_id : w_scan_idx;
  assign w_has_win = w_locked || w_scan_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lock_id <= '0;
      locked_o  <= 1'b0;
    end else if (w_hs) begin
      case (r_state)
        ST_IDLE: begin
          if (req_lock_i[w_win]) begin
            r_state   <= ST_LOCKED;
            r_lock_id <= w_win;
            locked_o  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          // A beat with lock clear closes the burst.
          if (!req_lock_i[w_win]) begin
            r_state  <= ST_IDLE;
            locked_o <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          locked_o <= 1'b0;
        end
      endcase
    end
  end
`else
  logic w_unused_lock;

  assign w_locked      = 1'b0;
  assign w_win         = w_scan_idx;
  assign w_has_win     = w_scan_found;
  assign locked_o      = 1'b0;
  assign w_unused_lock = ^req_lock_i;
`endif

  assign w_hs = w_has_win && req_valid_i[w_win] && w_can_load;

  always_comb begin
    req_ready_o = '0;
    if (w_hs) begin
      req_ready_o[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_win_data = req_data_i[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_hs) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_win_data;
        r_out_id    <= w_win;
        // The pointer is frozen while a lock holds the grant.
        if (!w_locked) begin
          r_ptr <= (w_win == c_last_id) ? '0 : w_win + ID_W'(1);
        end
      end else if (w_can_load) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign pipe_valid_o = r_out_valid;
  assign pipe_data_o  = r_out_data;
  assign pipe_id_o    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_arbiter
// Description : Self-checking bench for pipe_arbiter. A reference model
//               predicts grants from the arbitration rules, checks ready and
//               valid every cycle and queues expected beats; a monitor pops
//               and compares each beat that the pipe accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_lock_i;
  logic [N-1:0]    req_ready_o;
  logic            pipe_full_i;
  logic [DW-1:0]   pipe_data_o;
  logic            pipe_valid_o;
  logic [IW-1:0]   pipe_id_o;
  logic            locked_o;

  pipe_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_lock_i   (req_lock_i),
    .req_ready_o  (req_ready_o),
    .pipe_full_i  (pipe_full_i),
    .pipe_data_o  (pipe_data_o),
    .pipe_valid_o (pipe_valid_o),
    .pipe_id_o    (pipe_id_o),
    .locked_o     (locked_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester-side stimulus state
  logic [DW-1:0] data_r [N];
  logic [N-1:0]  last_acc;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_data_i[i*DW +: DW] = data_r[i];
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    int            id;
  } beat_t;

  beat_t sb[$];
  int    checks   = 0;
  int    failures = 0;

  // Reference model state
  bit m_out_valid;
  int m_ptr;
  bit m_locked;
  int m_lock_id;

`ifdef PIPE_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle once inputs and outputs are settled.
  always @(negedge clk) begin
    int       w;
    bit       has;
    bit       cl;
    bit       hs;
    logic [N-1:0] er;
    if (rst) begin
      chk("rst_pipe_valid", {63'd0, pipe_valid_o}, 64'd0);
      chk("rst_pipe_data", {32'd0, pipe_data_o}, 64'd0);
      chk("rst_pipe_id", {62'd0, pipe_id_o}, 64'd0);
      chk("rst_locked", {63'd0, locked_o}, 64'd0);
      m_out_valid = 1'b0;
      m_ptr       = 0;
      m_locked    = 1'b0;
      m_lock_id   = 0;
      sb.delete();
      last_acc    = '0;
    end else begin
      has = 1'b0;
      w   = 0;
      if (m_locked) begin
        has = 1'b1;
        w   = m_lock_id;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!has && req_valid_i[(m_ptr + k) % N]) begin
            has = 1'b1;
            w   = (m_ptr + k) % N;
          end
        end
      end
      cl = !m_out_valid || !pipe_full_i;
      hs = has && req_valid_i[w] && cl;
      er = '0;
      if (hs) er[w] = 1'b1;

      chk("ready", {60'd0, req_ready_o}, {60'd0, er});
      chk("pipe_valid", {63'd0, pipe_valid_o}, {63'd0, m_out_valid});
      chk("locked", {63'd0, locked_o}, {63'd0, m_locked});

      last_acc = req_ready_o & req_valid_i;

      if (hs) begin
        sb.push_back('{d: data_r[w], id: w});
        m_out_valid = 1'b1;
        if (!m_locked) m_ptr = (w + 1) % N;
        if (LOCK_EN) begin
          if (!m_locked && req_lock_i[w]) begin
            m_locked  = 1'b1;
            m_lock_id = w;
          end else if (m_locked && !req_lock_i[w]) begin
            m_locked = 1'b0;
          end
        end
      end else if (cl) begin
        m_out_valid = 1'b0;
      end
    end
  end

  // Monitor: compares the registered beat against the oldest expected one
  // and retires it when the pipe takes it.
  always @(negedge clk) begin
    if (!rst && pipe_valid_o) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        chk("beat_data", {32'd0, pipe_data_o}, {32'd0, sb[0].d});
        chk("beat_id", {62'd0, pipe_id_o}, 64'(sb[0].id));
        if (!pipe_full_i) void'(sb.pop_front());
      end
    end
  end

  // One cycle of stimulus. A requester holds valid, data and lock until it
  // is accepted; only then (or when idle) does it take a new request.
  task automatic step(input logic [N-1:0] want, input logic full,
                      input logic [N-1:0] lockv, input bit rnd);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (last_acc[i] || !req_valid_i[i]) begin
        req_valid_i[i] = rnd ? 1'($urandom_range(0, 1)) : want[i];
        data_r[i]      = $urandom;
        req_lock_i[i]  = rnd ? 1'($urandom_range(0, 1)) : lockv[i];
      end
    end
    pipe_full_i = rnd ? ($urandom_range(0, 3) == 0) : full;
  endtask

  initial begin
    int nb;
    rst         = 1'b1;
    req_valid_i = '0;
    req_lock_i  = '0;
    pipe_full_i = 1'b0;
    last_acc    = '0;
    for (int i = 0; i < N; i++) data_r[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single requester 2 with payload 0xA5
    step(4'b0100, 1'b0, 4'b0000, 1'b0);
    data_r[2] = 32'hA5;
    repeat (3) step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // All requesters continuously valid, pipe never full
    repeat (10) step(4'b1111, 1'b0, 4'b0000, 1'b0);

    // Pipe full for three cycles with the register occupied
    repeat (3) step(4'b1111, 1'b1, 4'b0000, 1'b0);
    repeat (4) step(4'b1111, 1'b0, 4'b0000, 1'b0);
    repeat (6) step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Pointer wrap: grant to 2 leaves ptr at 3, then 3 and 0 compete
    step(4'b0100, 1'b0, 4'b0000, 1'b0);
    step(4'b1001, 1'b0, 4'b0000, 1'b0);
    repeat (4) step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Lock burst: requester 1 sends three beats with lock 1,1,0
    nb = 0;
    for (int c = 0; c < 14; c++) begin
      if (last_acc[1]) nb++;
      step({1'b0, 1'b1, (nb < 3), 1'b1}, 1'b0, {2'b00, (nb < 2), 1'b0}, 1'b0);
    end
    repeat (6) step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Reset pulsed in the middle of a locked burst
    step(4'b0010, 1'b0, 4'b0010, 1'b0);
    step(4'b0010, 1'b1, 4'b0010, 1'b0);
    step(4'b0010, 1'b1, 4'b0010, 1'b0);
    rst = 1'b1;
    step(4'b1111, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    repeat (6) step(4'b1111, 1'b0, 4'b0000, 1'b0);

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 3000; c++) begin
      step(4'b0000, 1'b0, 4'b0000, 1'b1);
      if (c == 1500) begin
        rst = 1'b1;
        step(4'b0000, 1'b0, 4'b0000, 1'b1);
        rst = 1'b0;
      end
    end

    // Drain: no new requests, pipe free
    repeat (12) step(4'b0000, 1'b0, 4'b0000, 1'b0);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
